// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths and register indices.
package axi4_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 4;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned REG_IDX_W  = 2;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  localparam logic [REG_IDX_W-1:0] REG_CTRL0  = 2'd0;
  localparam logic [REG_IDX_W-1:0] REG_CTRL1  = 2'd1;
  localparam logic [REG_IDX_W-1:0] REG_CTRL2  = 2'd2;
  localparam logic [REG_IDX_W-1:0] REG_STATUS = 2'd3;

endpackage

// File: rtl/axi4_lite_slave_regfile.sv
// Three control registers with one write port, plus a combinational read mux
// that returns the user status word for the status index.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int unsigned       DATA_W    = AXI_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] widx,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] ridx,
  input  logic [DATA_W-1:0]    status_i,
  output logic [DATA_W-1:0]    rdata,
  output logic [DATA_W-1:0]    reg0_o,
  output logic [DATA_W-1:0]    reg1_o,
  output logic [DATA_W-1:0]    reg2_o
);

  logic [DATA_W-1:0] reg0_q;
  logic [DATA_W-1:0] reg1_q;
  logic [DATA_W-1:0] reg2_q;

  // Writes to the status index are dropped here; the top reports SLVERR.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      reg0_q <= RESET_VAL;
      reg1_q <= RESET_VAL;
      reg2_q <= RESET_VAL;
    end else if (we) begin
      case (widx)
        REG_CTRL0: reg0_q <= wdata;
        REG_CTRL1: reg1_q <= wdata;
        REG_CTRL2: reg2_q <= wdata;
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata = status_i;
    case (ridx)
      REG_CTRL0: rdata = reg0_q;
      REG_CTRL1: rdata = reg1_q;
      REG_CTRL2: rdata = reg2_q;
      default:   rdata = status_i;
    endcase
  end

  assign reg0_o = reg0_q;
  assign reg1_o = reg1_q;
  assign reg2_o = reg2_q;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating AW/W/B/AR/R on a 4-entry register bank
// (three R/W control registers, one read-only status word).
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int unsigned       ADDR_W    = AXI_ADDR_W,
  parameter int unsigned       DATA_W    = AXI_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(32'h0000_0000)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] reg0_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  input  logic [DATA_W-1:0] status_i
);

  logic                 rst_done;
  logic                 aw_full;
  logic                 w_full;
  logic [REG_IDX_W-1:0] aw_idx;
  logic [DATA_W-1:0]    w_data;
  logic                 bvalid;
  logic [1:0]           bresp_q;
  logic                 rvalid;
  logic [1:0]           rresp_q;
  logic [DATA_W-1:0]    rdata_q;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 ar_hs;
  logic                 commit;
  logic [REG_IDX_W-1:0] ar_idx;
  logic [DATA_W-1:0]    rd_data;
  logic                 unused_addr_bits;

  // Only bits [3:2] select a register; the rest of the address is ignored.
  assign unused_addr_bits = ^{AWADDR, ARADDR};
  assign ar_idx           = ARADDR[3:2];

  assign AWREADY = rst_done & ~aw_full;
  assign WREADY  = rst_done & ~w_full;
  assign ARREADY = rst_done & ~rvalid;
  assign BVALID  = bvalid;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // A new commit may land on the same edge the previous response is taken.
  assign commit = aw_full & w_full & (~bvalid | BREADY);

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // Write address / data holding slots.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
      end else if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= AWADDR[3:2];
      end
      if (commit) begin
        w_full <= 1'b0;
      end else if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
      end
    end
  end

  // Write response channel.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      bvalid  <= 1'b0;
      bresp_q <= 2'(OKAY);
    end else if (commit) begin
      bvalid  <= 1'b1;
      bresp_q <= (aw_idx == REG_STATUS) ? 2'(SLVERR) : 2'(OKAY);
    end else if (BREADY) begin
      bvalid  <= 1'b0;
    end
  end

  // Read channel; the read mux sees pre-edge register contents.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      rvalid  <= 1'b0;
      rresp_q <= 2'(OKAY);
      rdata_q <= '0;
    end else if (ar_hs) begin
      rvalid  <= 1'b1;
      rresp_q <= 2'(OKAY);
      rdata_q <= rd_data;
    end else if (RREADY) begin
      rvalid  <= 1'b0;
    end
  end

  axi4_lite_slave_regfile #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .we       (commit),
    .widx     (aw_idx),
    .wdata    (w_data),
    .ridx     (ar_idx),
    .status_i (status_i),
    .rdata    (rd_data),
    .reg0_o   (reg0_o),
    .reg1_o   (reg1_o),
    .reg2_o   (reg2_o)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed scenarios plus
// randomized transactions against a register-array reference model.
module tb_axi4_lite_slave_regs;

  localparam logic [31:0] RST_VAL = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] reg0_o;
  logic [31:0] reg1_o;
  logic [31:0] reg2_o;
  logic [31:0] status_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [3];

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_regs dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .status_i(status_i)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    return (idx == 2'd3) ? status_i : model[idx];
  endfunction

  task automatic test_reset();
    ARESETn = 1'b1;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0; status_i = '0;
    tick(); tick(); tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'd0 || RDATA !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy/vld/resp=%b rdata=%h want 0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, RDATA);
    end
    checks++;
    if (reg0_o !== RST_VAL || reg1_o !== RST_VAL || reg2_o !== RST_VAL) begin
      failures++;
      $display("FAIL reset_regs: got %h %h %h want %h", reg0_o, reg1_o, reg2_o, RST_VAL);
    end
    ARESETn = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      failures++;
      $display("FAIL ready_before_rst_done: got %b want 000", {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_rst_done: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    for (int i = 0; i < 3; i++) model[i] = RST_VAL;
  endtask

  task automatic test_write_same_edge();
    AWADDR = 4'h4; AWVALID = 1; WDATA = 32'hDEADBEEF; WVALID = 1; BREADY = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_accept: got bvalid=%b awready=%b want 0 0", BVALID, AWREADY);
    end
    tick();
    model[1] = 32'hDEADBEEF;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || reg1_o !== model[1]) begin
      failures++;
      $display("FAIL same_edge_commit: got bvalid=%b bresp=%b reg1=%h want 1 00 %h", BVALID, BRESP, reg1_o, model[1]);
    end
    tick();
    checks++;
    if (BVALID !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_bclear: got bvalid=%b want 0", BVALID);
    end
    BREADY = 0;
  endtask

  task automatic test_w_before_aw();
    WDATA = 32'h12345678; WVALID = 1;
    tick();
    WVALID = 0;
    checks++;
    if (WREADY !== 1'b0) begin
      failures++;
      $display("FAIL w_first_wready: got %b want 0", WREADY);
    end
    tick(); tick();
    AWADDR = 4'h8; AWVALID = 1;
    tick();
    AWVALID = 0;
    checks++;
    if (AWREADY !== 1'b0 || BVALID !== 1'b0) begin
      failures++;
      $display("FAIL w_first_aw_accept: got awready=%b bvalid=%b want 0 0", AWREADY, BVALID);
    end
    tick();
    model[2] = 32'h12345678;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || reg2_o !== model[2]) begin
      failures++;
      $display("FAIL w_first_commit: got bvalid=%b bresp=%b reg2=%h want 1 00 %h", BVALID, BRESP, reg2_o, model[2]);
    end
    BREADY = 1;
    tick();
    BREADY = 0;
    checks++;
    if (BVALID !== 1'b0) begin
      failures++;
      $display("FAIL w_first_bclear: got bvalid=%b want 0", BVALID);
    end
  endtask

  task automatic test_status_write();
    status_i = 32'hA5A5_0001;
    AWADDR = 4'hC; AWVALID = 1; WDATA = 32'hFFFFFFFF; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b10) begin
      failures++;
      $display("FAIL status_write_resp: got bvalid=%b bresp=%b want 1 10", BVALID, BRESP);
    end
    checks++;
    if (reg0_o !== model[0] || reg1_o !== model[1] || reg2_o !== model[2]) begin
      failures++;
      $display("FAIL status_write_regs: got %h %h %h want %h %h %h", reg0_o, reg1_o, reg2_o, model[0], model[1], model[2]);
    end
    BREADY = 1;
    tick();
    BREADY = 0;
    ARADDR = 4'hC; ARVALID = 1;
    tick();
    ARVALID = 0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'hA5A5_0001 || RRESP !== 2'b00) begin
      failures++;
      $display("FAIL status_read: got rvalid=%b rdata=%h rresp=%b want 1 a5a50001 00", RVALID, RDATA, RRESP);
    end
    RREADY = 1;
    tick();
    RREADY = 0;
    checks++;
    if (RVALID !== 1'b0) begin
      failures++;
      $display("FAIL status_read_rclear: got rvalid=%b want 0", RVALID);
    end
  endtask

  task automatic test_b_backpressure();
    logic [31:0] d1;
    d1 = $urandom;
    if (d1 == 32'h2) d1 = 32'h3;
    BREADY = 0;
    AWADDR = 4'h0; AWVALID = 1; WDATA = d1; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    model[0] = d1;
    checks++;
    if (BVALID !== 1'b1 || reg0_o !== d1) begin
      failures++;
      $display("FAIL bp_first_commit: got bvalid=%b reg0=%h want 1 %h", BVALID, reg0_o, d1);
    end
    AWADDR = 4'h0; AWVALID = 1; WDATA = 32'h2; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || reg0_o !== d1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got bvalid=%b bresp=%b reg0=%h want 1 00 %h", i, BVALID, BRESP, reg0_o, d1);
      end
      tick();
    end
    BREADY = 1;
    tick();
    model[0] = 32'h2;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || reg0_o !== 32'h2) begin
      failures++;
      $display("FAIL bp_second_commit: got bvalid=%b bresp=%b reg0=%h want 1 00 00000002", BVALID, BRESP, reg0_o);
    end
    tick();
    checks++;
    if (BVALID !== 1'b0) begin
      failures++;
      $display("FAIL bp_final_clear: got bvalid=%b want 0", BVALID);
    end
    BREADY = 0;
  endtask

  task automatic test_read_collision();
    logic [31:0] old;
    old = model[1];
    RREADY = 0; BREADY = 1;
    AWADDR = 4'h4; AWVALID = 1; WDATA = 32'h55; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    ARADDR = 4'h4; ARVALID = 1;
    tick();
    ARVALID = 0;
    model[1] = 32'h55;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== old || RRESP !== 2'b00) begin
      failures++;
      $display("FAIL collision_read: got rvalid=%b rdata=%h rresp=%b want 1 %h 00", RVALID, RDATA, RRESP, old);
    end
    checks++;
    if (reg1_o !== 32'h55 || BVALID !== 1'b1) begin
      failures++;
      $display("FAIL collision_write: got reg1=%h bvalid=%b want 00000055 1", reg1_o, BVALID);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RVALID !== 1'b1 || RDATA !== old || ARREADY !== 1'b0) begin
        failures++;
        $display("FAIL r_hold[%0d]: got rvalid=%b rdata=%h arready=%b want 1 %h 0", i, RVALID, RDATA, ARREADY, old);
      end
      tick();
    end
    RREADY = 1;
    tick();
    RREADY = 0; BREADY = 0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL r_release: got rvalid=%b arready=%b want 0 1", RVALID, ARREADY);
    end
  endtask

  task automatic test_reset_midtx();
    logic [31:0] wd;
    BREADY = 0; RREADY = 0;
    AWADDR = 4'h8; AWVALID = 1; WDATA = $urandom; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    AWADDR = 4'h0; AWVALID = 1; ARADDR = 4'h8; ARVALID = 1;
    tick();
    AWVALID = 0; ARVALID = 0;
    checks++;
    if (BVALID !== 1'b1 || AWREADY !== 1'b0 || RVALID !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_state: got bvalid=%b awready=%b rvalid=%b want 1 0 1", BVALID, AWREADY, RVALID);
    end
    #2;
    ARESETn = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) model[i] = RST_VAL;
    checks++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0 || AWREADY !== 1'b0 ||
        reg0_o !== RST_VAL || reg1_o !== RST_VAL || reg2_o !== RST_VAL) begin
      failures++;
      $display("FAIL async_reset: got bvalid=%b rvalid=%b awready=%b regs=%h %h %h want 0 0 0 %h", BVALID, RVALID, AWREADY, reg0_o, reg1_o, reg2_o, RST_VAL);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    wd = $urandom;
    WDATA = wd; WVALID = 1;
    tick();
    WVALID = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_spurious[%0d]: got bvalid=%b rvalid=%b want 0 0", i, BVALID, RVALID);
      end
      tick();
    end
    AWADDR = 4'h0; AWVALID = 1;
    tick();
    AWVALID = 0;
    tick();
    model[0] = wd;
    checks++;
    if (BVALID !== 1'b1 || reg0_o !== wd) begin
      failures++;
      $display("FAIL post_reset_write: got bvalid=%b reg0=%h want 1 %h", BVALID, reg0_o, wd);
    end
    BREADY = 1;
    tick();
    BREADY = 0;
  endtask

  task automatic test_random();
    logic [1:0]  idx;
    logic [1:0]  lo;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    int          mode;
    int          k;
    int          stall;
    for (int n = 0; n < 60; n++) begin
      idx  = 2'($urandom_range(0, 3));
      lo   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        mode = $urandom_range(0, 2);
        checks++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
          failures++;
          $display("FAIL rnd_idle_ready[%0d]: got awready=%b wready=%b want 1 1", n, AWREADY, WREADY);
        end
        AWADDR = {idx, lo}; WDATA = data;
        if (mode == 0) begin
          AWVALID = 1; WVALID = 1; tick(); AWVALID = 0; WVALID = 0;
        end else if (mode == 1) begin
          WVALID = 1; tick(); WVALID = 0; AWVALID = 1; tick(); AWVALID = 0;
        end else begin
          AWVALID = 1; tick(); AWVALID = 0; WVALID = 1; tick(); WVALID = 0;
        end
        exp_resp = (idx == 2'd3) ? 2'b10 : 2'b00;
        if (idx != 2'd3) model[idx] = data;
        k = 0;
        while (BVALID !== 1'b1 && k < 8) begin
          tick();
          k++;
        end
        checks++;
        if (BVALID !== 1'b1 || BRESP !== exp_resp) begin
          failures++;
          $display("FAIL rnd_bresp[%0d]: got bvalid=%b bresp=%b want 1 %b", n, BVALID, BRESP, exp_resp);
        end
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) tick();
        checks++;
        if (BVALID !== 1'b1 || BRESP !== exp_resp) begin
          failures++;
          $display("FAIL rnd_bhold[%0d]: got bvalid=%b bresp=%b want 1 %b", n, BVALID, BRESP, exp_resp);
        end
        BREADY = 1;
        tick();
        BREADY = 0;
        checks++;
        if (BVALID !== 1'b0 || reg0_o !== model[0] || reg1_o !== model[1] || reg2_o !== model[2]) begin
          failures++;
          $display("FAIL rnd_wregs[%0d]: got bvalid=%b regs=%h %h %h want 0 %h %h %h", n, BVALID, reg0_o, reg1_o, reg2_o, model[0], model[1], model[2]);
        end
      end else begin
        status_i = $urandom;
        checks++;
        if (ARREADY !== 1'b1) begin
          failures++;
          $display("FAIL rnd_arready[%0d]: got %b want 1", n, ARREADY);
        end
        ARADDR = {idx, lo}; ARVALID = 1;
        tick();
        ARVALID = 0;
        data = model_read(idx);
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) tick();
        checks++;
        if (RVALID !== 1'b1 || RDATA !== data || RRESP !== 2'b00) begin
          failures++;
          $display("FAIL rnd_read[%0d]: got rvalid=%b rdata=%h rresp=%b want 1 %h 00", n, RVALID, RDATA, RRESP, data);
        end
        RREADY = 1;
        tick();
        RREADY = 0;
        checks++;
        if (RVALID !== 1'b0) begin
          failures++;
          $display("FAIL rnd_rclear[%0d]: got rvalid=%b want 0", n, RVALID);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_same_edge();
    test_w_before_aw();
    test_status_write();
    test_b_backpressure();
    test_read_collision();
    test_reset_midtx();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite slave sitting directly downstream of the team's AXI4-Lite master. It terminates the AW/W/B/AR/R channels on a 4-entry, 32-bit register bank. Registers 0–2 are read/write control registers exported to user logic. Register 3 is a read-only status word driven by user logic.

Parameters:
ADDR_W, 4, AXI address width (byte address; bits [3:2] select register)
DATA_W, 32, data width of bus and registers
RESET_VAL, 32'h0000_0000, reset value of registers 0–2

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset, asynchronous, active-high (logic held in reset while ARESETn=1)
AWADDR  in  ADDR_W  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_W  write data
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg0_o, reg1_o, reg2_o  out  DATA_W each  current contents of registers 0–2
status_i  in  DATA_W  value returned when register 3 is read

Behaviour:
- Reset (ARESETn=1):
  - All handshake outputs are 0; BRESP, RRESP and RDATA are 0.
  - reg0–2 are set to RESET_VAL.
  - Internal flags aw_full, w_full, bvalid, rvalid and rst_done are all 0.
- rst_done goes to 1 on the first ACLK edge after reset release. All READY outputs are gated by rst_done.
- Address decode: idx = addr[3:2]; addr[1:0] are ignored.
- AW channel:
  - AWREADY = rst_done & !aw_full.
  - A handshake (AWVALID&AWREADY) at an edge latches the address and sets aw_full.
- W channel:
  - WREADY = rst_done & !w_full.
  - A handshake latches the data and sets w_full.
  - AW and W are accepted independently, in either order or on the same edge.
- Write commit: at an edge where aw_full & w_full & !bvalid:
  - If idx≠3, the register is written with the latched data.
  - BRESP = OKAY for idx≠3; for idx=3 there is no update and BRESP = SLVERR (2'b10).
  - bvalid is set; aw_full and w_full are cleared.
- Write latency: AW and W both accepted at edge E gives commit at E+1. BVALID is high from E+1 and reg*_o updates at E+1.
- B channel:
  - BVALID and BRESP are held stable until the BREADY edge, where bvalid clears.
  - While bvalid is set, a second AW/W may be latched, but no commit occurs until bvalid clears (the earliest next commit is the same edge bvalid clears, if both are latched).
- AR channel:
  - ARREADY = rst_done & !rvalid.
  - A handshake at edge E loads RDATA from reg[idx] (or status_i for idx=3), sets RRESP = OKAY, and sets rvalid.
  - RVALID is high from E (1-cycle latency).
- R channel: RDATA, RRESP and RVALID are held until the RREADY edge. A back-to-back AR is accepted only on the cycle after rvalid clears.
- Read/write collision: an AR handshake on the same edge as a commit to the same register returns the pre-commit value.
- Reads and writes are fully independent; no ordering between channels.
- Reset asserted mid-transaction: all latched AW/W and pending B/R responses are discarded immediately (asynchronous), and registers revert to RESET_VAL.
- All outputs are registered or gated by registered flags; there is no combinational path from input VALID to output READY.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - resp_e: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - AXI_ADDR_W=4, AXI_DATA_W=32
  - register index constants REG_CTRL0=0, REG_CTRL1=1, REG_CTRL2=2, REG_STATUS=3
- One natural sub-module, axi4_lite_slave_regfile: 3×32 storage plus the status mux, with a single write port (we, idx, wdata) and a combinational read port (idx → data).

Test Plan:
- Reset release, then AW 0x4 + W 0xDEADBEEF on the same edge, BREADY=1 → BVALID one cycle later, BRESP=00, reg1_o=0xDEADBEEF.
- W 0x12345678 three cycles before AW 0x8 → commit on the edge after AW, reg2_o=0x12345678, BRESP=00; AWREADY low on the cycle after AW acceptance.
- Write 0xC with data 0xFFFFFFFF, status_i=0xA5A5_0001 → BRESP=10, reg0–2 unchanged; a subsequent read of 0xC gives RDATA=0xA5A5_0001, RRESP=00.
- BREADY held low 5 cycles after a write to 0x0, with a second AW/W (0x0, 0x2) issued meanwhile → BVALID/BRESP stable; the second commit happens only on the edge BREADY is sampled high; reg0_o ends at 0x2.
- Read 0x4 with RREADY low for 4 cycles → RVALID/RDATA stable, ARREADY=0 throughout; a same-edge write of 0x55 to 0x4 alongside the AR handshake → read returns the old value.
- Assert ARESETn=1 while BVALID=1 and aw_full=1 → BVALID=0 immediately, reg*_o=RESET_VAL; after release no spurious BVALID/RVALID.
